// File: rtl/core_mem_lsu_if.sv
// Single-beat data bus between the MEM-stage load/store unit and memory.
// The LSU side is the master; the memory or interconnect is the slave.
interface core_mem_lsu_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic        dbus_ack;
    logic        dbus_err;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
        input  dbus_ack, dbus_err, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
        output dbus_ack, dbus_err, dbus_rdata
    );
endinterface

// File: rtl/core_mem_lsu.sv
// MEM-stage load/store unit: one request/ack bus transaction per operation,
// returns extended load data and flags misaligned or faulting accesses.
module core_mem_lsu #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TIMER_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] mem_rdata,
    output logic        exc_misaligned,
    output logic        exc_fault,
    core_mem_lsu_if.master dbus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TIMER_W-1:0] TO_LAST =
        TIMER_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t             state;
    logic [TIMER_W-1:0] cnt;
    logic [1:0]         r_size;
    logic [1:0]         r_off;
    logic               r_uns;

    logic        mis;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_val;

    assign mis = (size == 2'b11)
               | ((size == 2'b01) & addr[0])
               | ((size == 2'b10) & (|addr[1:0]));

    always_comb begin
        st_data = wdata;
        st_strb = 4'b1111;
        unique case (size)
            2'b00: begin
                st_data = {4{wdata[7:0]}};
                st_strb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_data = {2{wdata[15:0]}};
                st_strb = 4'b0011 << addr[1:0];
            end
            default: begin
                st_data = wdata;
                st_strb = 4'b1111;
            end
        endcase
        if (!we) st_strb = 4'b0000;
    end

    always_comb begin
        ld_b = dbus.dbus_rdata[7:0];
        unique case (r_off)
            2'd0: ld_b = dbus.dbus_rdata[7:0];
            2'd1: ld_b = dbus.dbus_rdata[15:8];
            2'd2: ld_b = dbus.dbus_rdata[23:16];
            default: ld_b = dbus.dbus_rdata[31:24];
        endcase
        ld_h = r_off[1] ? dbus.dbus_rdata[31:16] : dbus.dbus_rdata[15:0];
        unique case (r_size)
            2'b00:   ld_val = {{24{~r_uns & ld_b[7]}}, ld_b};
            2'b01:   ld_val = {{16{~r_uns & ld_h[15]}}, ld_h};
            default: ld_val = dbus.dbus_rdata;
        endcase
    end

    // Combinational in IDLE so EXEC holds its operands without a bubble.
    assign busy = ~rst & ((state == BUS) | ((state == IDLE) & req));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            r_size          <= 2'b00;
            r_off           <= 2'b00;
            r_uns           <= 1'b0;
            done            <= 1'b0;
            mem_rdata       <= 32'h0;
            exc_misaligned  <= 1'b0;
            exc_fault       <= 1'b0;
            dbus.dbus_req   <= 1'b0;
            dbus.dbus_we    <= 1'b0;
            dbus.dbus_addr  <= 32'h0;
            dbus.dbus_wdata <= 32'h0;
            dbus.dbus_wstrb <= 4'b0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req && mis) begin
                        state          <= RESP;
                        done           <= 1'b1;
                        exc_misaligned <= 1'b1;
                    end else if (req) begin
                        state           <= BUS;
                        cnt             <= '0;
                        r_size          <= size;
                        r_off           <= addr[1:0];
                        r_uns           <= is_unsigned;
                        dbus.dbus_req   <= 1'b1;
                        dbus.dbus_we    <= we;
                        dbus.dbus_addr  <= {addr[31:2], 2'b00};
                        dbus.dbus_wdata <= st_data;
                        dbus.dbus_wstrb <= st_strb;
                    end
                end
                BUS: begin
                    if (dbus.dbus_ack) begin
                        state         <= RESP;
                        done          <= 1'b1;
                        dbus.dbus_req <= 1'b0;
                        if (dbus.dbus_err) exc_fault <= 1'b1;
                        else if (!dbus.dbus_we) mem_rdata <= ld_val;
                    end else if (TO_EN && cnt == TO_LAST) begin
                        state         <= RESP;
                        done          <= 1'b1;
                        exc_fault     <= 1'b1;
                        dbus.dbus_req <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    done           <= 1'b0;
                    exc_misaligned <= 1'b0;
                    exc_fault      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
